// File: rtl/mem_responder.sv
// Memory end of the Read/Write bus: single-port word array with fixed read latency,
// one-cycle MemReady/Err pulses and Busy while a read is in flight. Optional macro MEM_BYTE_LANE_EN.
module mem_responder #(
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 9,
  parameter int DEPTH      = 512,
  parameter int RD_LATENCY = 2
) (
  input  logic                Clock,
  input  logic                Clear,
  input  logic                Read,
  input  logic                Write,
  input  logic [ADDR_W-1:0]   Addr,
  input  logic [DATA_W-1:0]   WrData,
`ifdef MEM_BYTE_LANE_EN
  input  logic [DATA_W/8-1:0] ByteEn,
`endif
  output logic [DATA_W-1:0]   Mdatain,
  output logic                MemReady,
  output logic                Busy,
  output logic                Err
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic {
    IDLE    = 1'b0,
    RD_WAIT = 1'b1
  } state_t;

  logic [DATA_W-1:0] r_mem [DEPTH];

  state_t            r_state;
  logic [3:0]        r_cnt;
  logic [IDX_W-1:0]  r_addr;
  logic              r_oor;
  logic [DATA_W-1:0] r_mdatain;
  logic              r_memready;
  logic              r_err;

  state_t            w_state_nx;
  logic [3:0]        w_cnt_nx;
  logic [IDX_W-1:0]  w_addr_nx;
  logic              w_oor_nx;
  logic [DATA_W-1:0] w_mdatain_nx;
  logic              w_memready_nx;
  logic              w_err_nx;
  logic              w_mem_we;
  logic              w_in_range;
  logic [IDX_W-1:0]  w_idx;

  assign w_in_range = (32'(Addr) < 32'(DEPTH));
  assign w_idx      = Addr[IDX_W-1:0];

  always_comb begin
    w_state_nx    = r_state;
    w_cnt_nx      = r_cnt;
    w_addr_nx     = r_addr;
    w_oor_nx      = r_oor;
    w_mdatain_nx  = r_mdatain;
    w_memready_nx = 1'b0;
    w_err_nx      = 1'b0;
    w_mem_we      = 1'b0;
    case (r_state)
      IDLE: begin
        if (Read && Write) begin
          w_err_nx = 1'b1;
        end else if (Write) begin
          if (w_in_range) begin
            w_mem_we      = !Clear;
            w_memready_nx = 1'b1;
          end else begin
            w_err_nx = 1'b1;
          end
        end else if (Read) begin
          if (RD_LATENCY == 1) begin
            w_mdatain_nx  = w_in_range ? r_mem[w_idx] : '0;
            w_memready_nx = 1'b1;
            w_err_nx      = !w_in_range;
          end else begin
            // cnt holds the number of wait edges left before the completion edge
            w_addr_nx  = w_idx;
            w_oor_nx   = !w_in_range;
            w_cnt_nx   = 4'(RD_LATENCY - 2);
            w_state_nx = RD_WAIT;
          end
        end
      end
      RD_WAIT: begin
        w_err_nx = Read || Write;
        if (r_cnt == 4'd0) begin
          w_mdatain_nx  = r_oor ? '0 : r_mem[r_addr];
          w_memready_nx = 1'b1;
          w_err_nx      = w_err_nx || r_oor;
          w_state_nx    = IDLE;
        end else begin
          w_cnt_nx = r_cnt - 4'd1;
        end
      end
      default: w_state_nx = IDLE;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (Clear) begin
      r_state    <= IDLE;
      r_cnt      <= '0;
      r_addr     <= '0;
      r_oor      <= 1'b0;
      r_mdatain  <= '0;
      r_memready <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_state    <= w_state_nx;
      r_cnt      <= w_cnt_nx;
      r_addr     <= w_addr_nx;
      r_oor      <= w_oor_nx;
      r_mdatain  <= w_mdatain_nx;
      r_memready <= w_memready_nx;
      r_err      <= w_err_nx;
    end
  end

  // Array contents survive Clear; only the write path is gated by it.
  always_ff @(posedge Clock) begin
    if (w_mem_we) begin
`ifdef MEM_BYTE_LANE_EN
      for (int i = 0; i < DATA_W/8; i++) begin
        if (ByteEn[i]) r_mem[w_idx][8*i +: 8] <= WrData[8*i +: 8];
      end
`else
      r_mem[w_idx] <= WrData;
`endif
    end
  end

  assign Mdatain  = r_mdatain;
  assign MemReady = r_memready;
  assign Busy     = (r_state == RD_WAIT);
  assign Err      = r_err;

endmodule

// File: tb/tb_mem_responder.sv
// Self-checking bench for mem_responder: directed scenarios followed by randomized
// transactions compared against a word-array reference model.
module tb_mem_responder;
  localparam int DW    = 32;
  localparam int AW    = 9;
  localparam int DEPTH = 256;
  localparam int LAT   = 2;

  logic          Clock = 1'b0;
  logic          Clear = 1'b1;
  logic          Read  = 1'b0;
  logic          Write = 1'b0;
  logic [AW-1:0] Addr  = '0;
  logic [DW-1:0] WrData = '0;
`ifdef MEM_BYTE_LANE_EN
  logic [DW/8-1:0] ByteEn = '1;
`endif
  logic [DW-1:0] Mdatain;
  logic          MemReady;
  logic          Busy;
  logic          Err;

  int n_cmp = 0;
  int n_err = 0;
  logic [DW-1:0] mdl [DEPTH];
  logic [DW-1:0] last_rd;

  mem_responder #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(DEPTH), .RD_LATENCY(LAT)) dut (
    .Clock(Clock), .Clear(Clear), .Read(Read), .Write(Write), .Addr(Addr), .WrData(WrData),
`ifdef MEM_BYTE_LANE_EN
    .ByteEn(ByteEn),
`endif
    .Mdatain(Mdatain), .MemReady(MemReady), .Busy(Busy), .Err(Err)
  );

  always #5 Clock = ~Clock;

  task automatic step();
    @(posedge Clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [3:0] be);
    bit oor;
    oor = (int'(a) >= DEPTH);
    Write = 1'b1; Addr = a; WrData = d;
`ifdef MEM_BYTE_LANE_EN
    ByteEn = be;
`endif
    step();
    Write = 1'b0;
    chk("wr_rdy", MemReady, oor ? 0 : 1);
    chk("wr_err", Err, oor ? 1 : 0);
    chk("wr_hold", Mdatain, last_rd);
    if (!oor) begin
      for (int i = 0; i < DW/8; i++) begin
`ifdef MEM_BYTE_LANE_EN
        if (be[i]) mdl[a[7:0]][8*i +: 8] = d[8*i +: 8];
`else
        if (be[i] || !be[i]) mdl[a[7:0]][8*i +: 8] = d[8*i +: 8];
`endif
      end
    end
  endtask

  // A read occupies LAT edges; intr injects a second request during the first busy cycle.
  task automatic rd(input logic [AW-1:0] a, input bit intr, input bit intr_wr);
    bit oor;
    logic [DW-1:0] exp;
    oor = (int'(a) >= DEPTH);
    exp = oor ? '0 : mdl[a[7:0]];
    Read = 1'b1; Addr = a;
    step();
    Read = 1'b0;
    for (int j = 1; j <= LAT - 1; j++) begin
      chk("rd_busy", Busy, 1);
      chk("rd_rdy_early", MemReady, 0);
      chk("rd_err_wait", Err, (intr && j == 2) ? 1 : 0);
      chk("rd_hold", Mdatain, last_rd);
      if (intr && j == 1) begin
        if (intr_wr) begin
          Write = 1'b1; WrData = 32'hDEADBEEF ^ $urandom; Addr = a;
        end else begin
          Read = 1'b1; Addr = AW'($urandom);
        end
      end
      step();
      Write = 1'b0; Read = 1'b0;
    end
    chk("rd_rdy", MemReady, 1);
    chk("rd_data", Mdatain, exp);
    chk("rd_err_done", Err, (oor || (intr && LAT == 2)) ? 1 : 0);
    chk("rd_busy_done", Busy, 0);
    last_rd = exp;
  endtask

  task automatic both(input logic [AW-1:0] a);
    Read = 1'b1; Write = 1'b1; Addr = a; WrData = $urandom;
    step();
    Read = 1'b0; Write = 1'b0;
    chk("both_err", Err, 1);
    chk("both_rdy", MemReady, 0);
    chk("both_busy", Busy, 0);
  endtask

  task automatic idle();
    step();
    chk("idle_rdy", MemReady, 0);
    chk("idle_err", Err, 0);
    chk("idle_busy", Busy, 0);
    chk("idle_hold", Mdatain, last_rd);
  endtask

  initial begin
    last_rd = '0;
    // reset
    step();
    Clear = 1'b0;
    chk("rst_mdat", Mdatain, 0);
    chk("rst_rdy", MemReady, 0);
    chk("rst_busy", Busy, 0);
    chk("rst_err", Err, 0);

    for (int i = 0; i < DEPTH; i++) wr(AW'(i), $urandom, 4'hF);

    // write then read back
    wr(9'd5, 32'h6108001A, 4'hF);
    rd(9'd5, 1'b0, 1'b0);
    chk("t2_data", Mdatain, 32'h6108001A);

    // simultaneous Read/Write rejected
    both(9'd5);
    rd(9'd5, 1'b0, 1'b0);
    chk("t3_data", Mdatain, 32'h6108001A);

    // write while busy rejected, in-flight read unaffected
    rd(9'd5, 1'b1, 1'b1);
    chk("t4_data", Mdatain, 32'h6108001A);
    rd(9'd5, 1'b0, 1'b0);
    chk("t4_reread", Mdatain, 32'h6108001A);

    // out-of-range read and write
    rd(9'h1FF, 1'b0, 1'b0);
    chk("t5_oor_data", Mdatain, 0);
    wr(9'h100, 32'h12345678, 4'hF);

    // Clear during a read in flight
    rd(9'd5, 1'b0, 1'b0);
    Read = 1'b1; Addr = 9'd5;
    step();
    Read = 1'b0;
    chk("clr_busy_before", Busy, 1);
    Clear = 1'b1;
    step();
    Clear = 1'b0;
    chk("clr_mdat", Mdatain, 0);
    chk("clr_rdy", MemReady, 0);
    chk("clr_busy", Busy, 0);
    last_rd = '0;
    idle();

    // adjacent write then read of the same word
    wr(9'd9, 32'hCAFEF00D, 4'hF);
    rd(9'd9, 1'b0, 1'b0);
    chk("raw_data", Mdatain, 32'hCAFEF00D);

`ifdef MEM_BYTE_LANE_EN
    wr(9'd7, 32'h0, 4'hF);
    wr(9'd7, 32'hAABBCCDD, 4'b0101);
    rd(9'd7, 1'b0, 1'b0);
    chk("be_data", Mdatain, 32'h00BB00DD);
    wr(9'd7, 32'h11111111, 4'b0000);
    rd(9'd7, 1'b0, 1'b0);
    chk("be_none", Mdatain, 32'h00BB00DD);
`endif

    for (int n = 0; n < 200; n++) begin
      int op;
      logic [AW-1:0] a;
      op = $urandom_range(0, 9);
      a = ($urandom_range(0, 7) == 0) ? AW'($urandom_range(DEPTH, 511)) : AW'($urandom_range(0, DEPTH - 1));
      if (op <= 3)      wr(a, $urandom, 4'($urandom));
      else if (op <= 6) rd(a, $urandom_range(0, 2) == 0, $urandom_range(0, 1) == 1);
      else if (op == 7) both(a);
      else              idle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
